// File: rtl/relu_maxpool2.sv
// ReLU followed by 2x2/stride-2 max pooling over a raster-order feature map.
// Define RELU_MAXPOOL2_SAT_EN to saturate pooled values above 4095 instead of truncating them.
module relu_maxpool2 #(
    parameter int IN_WIDTH  = 8,
    parameter int IN_HEIGHT = 8,
    parameter int DATA_BITS = 14
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid_in,
    input  logic signed [DATA_BITS-1:0] conv_in,
    output logic [11:0]                 pool_out,
    output logic                        valid_out,
    output logic                        frame_done
);
    localparam int VW = DATA_BITS - 1;
    localparam int CW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int RW = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
    localparam int BW = (IN_WIDTH / 2 > 1) ? $clog2(IN_WIDTH / 2) : 1;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [VW-1:0] pair_q, pair_d;
    logic [11:0]   pool_out_q, pool_out_d;
    logic          valid_out_q, valid_out_d;
    logic          frame_done_q, frame_done_d;

    // Per-column maxima of the even row, consumed by the following odd row.
    logic [VW-1:0] buf_mem [IN_WIDTH/2];
    logic [BW-1:0] buf_idx;
    logic [VW-1:0] buf_rd;
    logic [VW-1:0] buf_wdata;
    logic          buf_we;

    logic          accept;
    logic          col_last;
    logic          row_last;
    logic [VW-1:0] relu_val;
    logic [VW-1:0] pair_max;
    logic [VW-1:0] max_val;

    always_comb begin
        accept    = valid_in && rst_n;
        col_last  = (col_q == CW'(IN_WIDTH - 1));
        row_last  = (row_q == RW'(IN_HEIGHT - 1));
        relu_val  = conv_in[DATA_BITS-1] ? '0 : conv_in[VW-1:0];
        buf_idx   = BW'(col_q >> 1);
        buf_rd    = buf_mem[buf_idx];
        pair_max  = (pair_q > relu_val) ? pair_q : relu_val;
        max_val   = (buf_rd > pair_max) ? buf_rd : pair_max;
        buf_wdata = pair_max;
        buf_we    = 1'b0;

        col_d        = col_q;
        row_d        = row_q;
        pair_d       = pair_q;
        pool_out_d   = pool_out_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;

        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            if (!col_q[0]) begin
                pair_d = relu_val;
            end else if (!row_q[0]) begin
                buf_we = 1'b1;
            end else begin
`ifdef RELU_MAXPOOL2_SAT_EN
                pool_out_d = (32'(max_val) > 32'd4095) ? 12'hFFF : 12'(max_val);
`else
                pool_out_d = 12'(max_val);
`endif
                valid_out_d  = 1'b1;
                frame_done_d = row_last && col_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            pair_q       <= '0;
            pool_out_q   <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            pair_q       <= pair_d;
            pool_out_q   <= pool_out_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Buffer contents need no reset: every entry is rewritten on an even row before it is read.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_mem[buf_idx] <= buf_wdata;
        end
    end

    assign pool_out   = pool_out_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_relu_maxpool2.sv
// Self-checking bench for relu_maxpool2: frame-level reference model plus directed literal checks.
module tb_relu_maxpool2;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int DB = 14;
`ifdef RELU_MAXPOOL2_SAT_EN
    localparam int BIG_EXP = 4095;
`else
    localparam int BIG_EXP = 904;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 valid_in = 1'b0;
    logic signed [DB-1:0] conv_in = '0;
    logic [11:0]          pool_out;
    logic                 valid_out;
    logic                 frame_done;

    relu_maxpool2 #(.IN_WIDTH(W), .IN_HEIGHT(H), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .conv_in    (conv_in),
        .pool_out   (pool_out),
        .valid_out  (valid_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: sample index within the frame and the ReLU'd frame image.
    int idx = 0;
    int frame_img [H][W];
    int e_pool = 0;
    bit e_valid = 1'b0;
    bit e_fd = 1'b0;

    int got [$];
    int fd_pos = -1;
    int pat [H][W];
    int ramp_exp [16] = '{9, 11, 13, 15, 25, 27, 29, 31, 41, 43, 45, 47, 57, 59, 61, 63};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int reduce12(input int m);
`ifdef RELU_MAXPOOL2_SAT_EN
        return (m > 4095) ? 4095 : m;
`else
        return m % 4096;
`endif
    endfunction

    // One clock: drive inputs, advance the model at the edge, compare all outputs after it.
    task automatic step(input bit v, input int d, input bit rn);
        logic signed [DB-1:0] ds;
        int r, c, rv, m;
        ds = DB'(d);
        valid_in = v;
        conv_in  = ds;
        rst_n    = rn;
        @(posedge clk);
        if (!rn) begin
            idx = 0; e_pool = 0; e_valid = 1'b0; e_fd = 1'b0;
        end else begin
            e_valid = 1'b0;
            e_fd    = 1'b0;
            if (v) begin
                r  = idx / W;
                c  = idx % W;
                rv = (ds < 0) ? 0 : int'(ds);
                frame_img[r][c] = rv;
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    m = rv;
                    if (frame_img[r-1][c-1] > m) m = frame_img[r-1][c-1];
                    if (frame_img[r-1][c]   > m) m = frame_img[r-1][c];
                    if (frame_img[r][c-1]   > m) m = frame_img[r][c-1];
                    e_pool  = reduce12(m);
                    e_valid = 1'b1;
                    e_fd    = (idx == W * H - 1);
                end
                idx = (idx + 1) % (W * H);
            end
        end
        #1;
        check("valid_out", int'(valid_out), int'(e_valid));
        check("frame_done", int'(frame_done), int'(e_fd));
        check("pool_out", int'(pool_out), e_pool);
        if (valid_out) begin
            got.push_back(int'(pool_out));
            if (frame_done) fd_pos = got.size() - 1;
            $display("out %0d value=%0d frame_done=%0b", got.size() - 1, pool_out, frame_done);
        end
    endtask

    task automatic pix(input int val, input int gap);
        for (int g = 0; g < gap; g++) step(1'b0, int'($urandom_range(0, 16383)) - 8192, 1'b1);
        step(1'b1, val, 1'b1);
    endtask

    task automatic send_pat(input int gap);
        got.delete();
        fd_pos = -1;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                pix(pat[r][c], gap);
    endtask

    task automatic check_ramp(input string tag);
        check({tag, "_count"}, got.size(), 16);
        for (int i = 0; i < 16; i++)
            check({tag, "_val"}, (i < got.size()) ? got[i] : -1, ramp_exp[i]);
        check({tag, "_fd_pos"}, fd_pos, 15);
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                pat[r][c] = r * 8 + c;
    endtask

    task automatic fill_const(input int v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                pat[r][c] = v;
    endtask

    initial begin
        step(1'b1, 123, 1'b0);
        step(1'b1, 45, 1'b0);
        check("reset_pool_out", int'(pool_out), 0);
        check("reset_valid_out", int'(valid_out), 0);

        fill_ramp();
        send_pat(0);
        check_ramp("ramp");

        fill_const(-100);
        send_pat(0);
        check("neg_count", got.size(), 16);
        for (int i = 0; i < got.size(); i++) check("neg_val", got[i], 0);

        fill_const(0);
        pat[2][4] = -5; pat[2][5] = 7; pat[3][4] = 300; pat[3][5] = 2;
        send_pat(0);
        check("window300", (got.size() > 6) ? got[6] : -1, 300);

        fill_const(0);
        pat[4][0] = 5000;
        send_pat(1);
        check("window5000", (got.size() > 8) ? got[8] : -1, BIG_EXP);

        fill_ramp();
        send_pat(2);
        check_ramp("ramp_gap3");

        for (int i = 0; i < 20; i++) pix(int'($urandom_range(0, 16383)) - 8192, 0);
        step(1'b1, 999, 1'b0);
        fill_ramp();
        send_pat(0);
        check_ramp("after_reset");

        for (int i = 0; i < 6 * W * H; i++) begin
            if ($urandom_range(0, 99) == 0) step(1'b1, 77, 1'b0);
            pix(int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
